clk_display_mux: RTL and testbench
==================================

// Module: clk_display_mux
// PURPOSE
//  Downstream consumer of the seconds/minutes counters: renders MM:SS on a
//  4-digit multiplexed 7-segment display. Snapshots both binary counts once
//  per scan frame, converts them to BCD with a sequential subtract-10 FSM,
//  and time-multiplexes digit enables and segments at a fixed refresh rate.
// PARAMETERS
//  REFRESH_DIV    50000  clk cycles per digit slot; must be >= 16
//  SEG_ACTIVE_LOW 1      1: seg_out/dp_out driven low = lit; 0: high = lit
//  DIG_ACTIVE_LOW 1      1: dig_en low = digit on; 0: high = digit on
// PORTS
//  clk         in   1  system clock
//  reset       in   1  synchronous, active-high reset
//  seconds_in  in   6  binary seconds, 0..59
//  minutes_in  in   6  binary minutes, 0..59
//  seg_out     out  7  segments {g,f,e,d,c,b,a}, bit0 = a
//  dp_out      out  1  decimal point, used as the colon
//  dig_en      out  4  [0]=sec units [1]=sec tens [2]=min units [3]=min tens
// BEHAVIOUR
//  - Reset: all outputs are inactive per polarity params (dig_en all off,
//    seg_out all off, dp_out off). refresh_cnt=0, digit_idx=0, snapshots=0,
//    BCD regs=0, FSM=IDLE.
//  - refresh_cnt counts 0..REFRESH_DIV-1, then wraps to 0.
//  - On the wrap, digit_idx increments 0->1->2->3->0.
//  - Cycle with refresh_cnt==0 in every slot is the blanking cycle: dig_en all
//    off (anti-ghosting). Cycles 1..REFRESH_DIV-1 enable dig_en[digit_idx].
//  - Snapshot: on the cycle where digit_idx==3 and refresh_cnt==0, latch
//    seconds_in and minutes_in, then start the converter.
//  - New values appear from the next digit-0 slot. The frame in progress keeps
//    showing the old BCD; there is no tearing within a frame.
//  - Converter FSM:
//    - IDLE -> LOAD on snapshot.
//    - LOAD: work=sec_snap, tens=0, sel=SEC.
//    - SUB: if work>=10 then work-=10 and tens++, else store units/tens for
//      sel. After SEC, reload with min_snap and repeat; after MIN go to DONE.
//    - DONE -> IDLE; the BCD output regs update here.
//    - Worst case is 16 cycles, so it always finishes inside one slot.
//  - Range: a snapshot value >59 sets a per-pair invalid flag. Both digits of
//    that pair then show a dash (g only) instead of BCD.
//  - Encoding, active-high gfedcba:
//    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F dash=40 blank=00.
//    Invert the encoding when SEG_ACTIVE_LOW=1.
//  - Leading zeros are displayed (00:00, not blank).
//  - dp_out is lit only during the digit_idx==2 slot, outside the blanking
//    cycle (see CONFIGURATION).
//  - All outputs are registered: 1 cycle of latency from digit_idx/BCD to the pins.
//  - Reset mid-frame or mid-conversion: abort to the reset state on the next edge.
//    The display is blank until the first post-reset frame.
//  - Input changes outside the snapshot cycle are ignored.
// CONFIGURATION
//  COLON_BLINK_EN defined:
//    - dp on digit 2 is lit only when sec_snap[0]==0, so the colon blinks at 0.5 Hz.
//    - Invalid seconds force the colon off.
//  COLON_BLINK_EN undefined:
//    - dp on digit 2 is lit in every digit-2 slot. No blink logic is built.
// TESTING (REFRESH_DIV=16, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=0)
//  1. Reset high 3 cycles -> seg_out=00, dig_en=0000, dp_out=0. Release ->
//     first enabled digit is 0001 at refresh_cnt==1, one cycle later (registered).
//  2. sec=37, min=05, run 2 frames ->
//     - slot0 seg=07, slot1 seg=4F, slot2 seg=6D with dp=1, slot3 seg=3F.
//     - dig_en is one-hot in order 0001, 0010, 0100, 1000.
//     - dig_en=0000 in each blanking cycle.
//  3. Change sec 37->38 in the middle of slot1 -> the current frame still
//     shows 7. The next frame shows 8. The converter completes <=16 cycles
//     after the snapshot.
//  4. sec=59, min=59 -> 5,9,5,9. Then sec=63 -> both seconds digits=40
//     (dash), minutes still 59.
//  5. Assert reset during converter SUB -> next cycle all outputs are
//     inactive and the FSM is IDLE. After release, the first valid frame
//     shows the fresh snapshot.
//  6. COLON_BLINK_EN: sec=10 -> dp=1 in slot2; sec=11 -> dp=0.
//     Without the macro: dp=1 for both.

Source files
------------

// File: rtl/clk_display_mux.sv
// MM:SS renderer for a 4-digit multiplexed 7-segment display.
// Optional COLON_BLINK_EN: colon lit only on even, valid seconds.
module clk_display_mux #(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seconds_in,
    input  logic [5:0] minutes_in,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [3:0] dig_en
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0] SEG_DASH = 7'h40;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SUB,
        DONE
    } conv_state_t;

    typedef enum logic {
        SEL_SEC,
        SEL_MIN
    } sel_t;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]    digit_idx_q, digit_idx_d;
    logic [5:0]    sec_snap_q, sec_snap_d;
    logic [5:0]    min_snap_q, min_snap_d;

    conv_state_t   state_q, state_d;
    sel_t          sel_q, sel_d;
    logic [5:0]    work_q, work_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    sec_ones_t_q, sec_ones_t_d;
    logic [3:0]    sec_tens_t_q, sec_tens_t_d;
    logic [3:0]    min_ones_t_q, min_ones_t_d;
    logic [3:0]    min_tens_t_q, min_tens_t_d;

    logic [3:0]    bcd_sec_ones_q, bcd_sec_ones_d;
    logic [3:0]    bcd_sec_tens_q, bcd_sec_tens_d;
    logic [3:0]    bcd_min_ones_q, bcd_min_ones_d;
    logic [3:0]    bcd_min_tens_q, bcd_min_tens_d;
    logic          bcd_sec_bad_q, bcd_sec_bad_d;
    logic          bcd_min_bad_q, bcd_min_bad_d;
    logic          bcd_valid_q, bcd_valid_d;

    logic [3:0]    disp_sec_ones_q, disp_sec_ones_d;
    logic [3:0]    disp_sec_tens_q, disp_sec_tens_d;
    logic [3:0]    disp_min_ones_q, disp_min_ones_d;
    logic [3:0]    disp_min_tens_q, disp_min_tens_d;
    logic          disp_sec_bad_q, disp_sec_bad_d;
    logic          disp_min_bad_q, disp_min_bad_d;
    logic          disp_valid_q, disp_valid_d;

    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    dig_q, dig_d;

    logic          cnt_wrap;
    logic          blank;
    logic          snap;
    logic          frame_load;
    logic [3:0]    digit_val;
    logic          pair_bad;
    logic          colon_on;
    logic [6:0]    seg_hi;
    logic [3:0]    dig_hi;
    logic          dp_hi;

    always_comb begin
        cnt_wrap      = (refresh_cnt_q == CNT_MAX);
        refresh_cnt_d = cnt_wrap ? '0 : refresh_cnt_q + 1'b1;
        digit_idx_d   = cnt_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
        blank         = (refresh_cnt_q == '0);
        snap          = blank && (digit_idx_q == 2'd3);
        frame_load    = blank && (digit_idx_q == 2'd0);
        sec_snap_d    = snap ? seconds_in : sec_snap_q;
        min_snap_d    = snap ? minutes_in : min_snap_q;
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        work_d         = work_q;
        tens_d         = tens_q;
        sec_ones_t_d   = sec_ones_t_q;
        sec_tens_t_d   = sec_tens_t_q;
        min_ones_t_d   = min_ones_t_q;
        min_tens_t_d   = min_tens_t_q;
        bcd_sec_ones_d = bcd_sec_ones_q;
        bcd_sec_tens_d = bcd_sec_tens_q;
        bcd_min_ones_d = bcd_min_ones_q;
        bcd_min_tens_d = bcd_min_tens_q;
        bcd_sec_bad_d  = bcd_sec_bad_q;
        bcd_min_bad_d  = bcd_min_bad_q;
        bcd_valid_d    = bcd_valid_q;
        unique case (state_q)
            IDLE: begin
                if (snap) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                work_d  = sec_snap_q;
                tens_d  = 4'd0;
                sel_d   = SEL_SEC;
                state_d = SUB;
            end
            SUB: begin
                if (work_q >= 6'd10) begin
                    work_d = work_q - 6'd10;
                    tens_d = tens_q + 4'd1;
                end else if (sel_q == SEL_SEC) begin
                    sec_ones_t_d = work_q[3:0];
                    sec_tens_t_d = tens_q;
                    work_d       = min_snap_q;
                    tens_d       = 4'd0;
                    sel_d        = SEL_MIN;
                end else begin
                    min_ones_t_d = work_q[3:0];
                    min_tens_t_d = tens_q;
                    state_d      = DONE;
                end
            end
            DONE: begin
                bcd_sec_ones_d = sec_ones_t_q;
                bcd_sec_tens_d = sec_tens_t_q;
                bcd_min_ones_d = min_ones_t_q;
                bcd_min_tens_d = min_tens_t_q;
                bcd_sec_bad_d  = (sec_snap_q > 6'd59);
                bcd_min_bad_d  = (min_snap_q > 6'd59);
                bcd_valid_d    = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latching from the _d side also catches a conversion finishing this cycle.
    always_comb begin
        disp_sec_ones_d = frame_load ? bcd_sec_ones_d : disp_sec_ones_q;
        disp_sec_tens_d = frame_load ? bcd_sec_tens_d : disp_sec_tens_q;
        disp_min_ones_d = frame_load ? bcd_min_ones_d : disp_min_ones_q;
        disp_min_tens_d = frame_load ? bcd_min_tens_d : disp_min_tens_q;
        disp_sec_bad_d  = frame_load ? bcd_sec_bad_d  : disp_sec_bad_q;
        disp_min_bad_d  = frame_load ? bcd_min_bad_d  : disp_min_bad_q;
        disp_valid_d    = frame_load ? bcd_valid_d    : disp_valid_q;
    end

    always_comb begin
        digit_val = 4'd0;
        pair_bad  = 1'b0;
        unique case (digit_idx_q)
            2'd0: begin
                digit_val = disp_sec_ones_q;
                pair_bad  = disp_sec_bad_q;
            end
            2'd1: begin
                digit_val = disp_sec_tens_q;
                pair_bad  = disp_sec_bad_q;
            end
            2'd2: begin
                digit_val = disp_min_ones_q;
                pair_bad  = disp_min_bad_q;
            end
            2'd3: begin
                digit_val = disp_min_tens_q;
                pair_bad  = disp_min_bad_q;
            end
            default: begin
                digit_val = 4'd0;
                pair_bad  = 1'b0;
            end
        endcase
    end

`ifdef COLON_BLINK_EN
    // Units digit parity equals seconds parity, so it tracks the snapshot.
    always_comb begin
        colon_on = !disp_sec_ones_q[0] && !disp_sec_bad_q;
    end
`else
    always_comb begin
        colon_on = 1'b1;
    end
`endif

    always_comb begin
        seg_hi = 7'h00;
        dig_hi = 4'h0;
        dp_hi  = 1'b0;
        if (!blank) begin
            dig_hi = 4'b0001 << digit_idx_q;
            if (disp_valid_q) begin
                seg_hi = pair_bad ? SEG_DASH : seg7(digit_val);
                dp_hi  = (digit_idx_q == 2'd2) && colon_on;
            end
        end
        seg_d = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        dp_d  = SEG_ACTIVE_LOW ? ~dp_hi : dp_hi;
        dig_d = DIG_ACTIVE_LOW ? ~dig_hi : dig_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_q   <= '0;
            digit_idx_q     <= 2'd0;
            sec_snap_q      <= 6'd0;
            min_snap_q      <= 6'd0;
            state_q         <= IDLE;
            sel_q           <= SEL_SEC;
            work_q          <= 6'd0;
            tens_q          <= 4'd0;
            sec_ones_t_q    <= 4'd0;
            sec_tens_t_q    <= 4'd0;
            min_ones_t_q    <= 4'd0;
            min_tens_t_q    <= 4'd0;
            bcd_sec_ones_q  <= 4'd0;
            bcd_sec_tens_q  <= 4'd0;
            bcd_min_ones_q  <= 4'd0;
            bcd_min_tens_q  <= 4'd0;
            bcd_sec_bad_q   <= 1'b0;
            bcd_min_bad_q   <= 1'b0;
            bcd_valid_q     <= 1'b0;
            disp_sec_ones_q <= 4'd0;
            disp_sec_tens_q <= 4'd0;
            disp_min_ones_q <= 4'd0;
            disp_min_tens_q <= 4'd0;
            disp_sec_bad_q  <= 1'b0;
            disp_min_bad_q  <= 1'b0;
            disp_valid_q    <= 1'b0;
            seg_q           <= SEG_OFF;
            dp_q            <= SEG_ACTIVE_LOW;
            dig_q           <= DIG_OFF;
        end else begin
            refresh_cnt_q   <= refresh_cnt_d;
            digit_idx_q     <= digit_idx_d;
            sec_snap_q      <= sec_snap_d;
            min_snap_q      <= min_snap_d;
            state_q         <= state_d;
            sel_q           <= sel_d;
            work_q          <= work_d;
            tens_q          <= tens_d;
            sec_ones_t_q    <= sec_ones_t_d;
            sec_tens_t_q    <= sec_tens_t_d;
            min_ones_t_q    <= min_ones_t_d;
            min_tens_t_q    <= min_tens_t_d;
            bcd_sec_ones_q  <= bcd_sec_ones_d;
            bcd_sec_tens_q  <= bcd_sec_tens_d;
            bcd_min_ones_q  <= bcd_min_ones_d;
            bcd_min_tens_q  <= bcd_min_tens_d;
            bcd_sec_bad_q   <= bcd_sec_bad_d;
            bcd_min_bad_q   <= bcd_min_bad_d;
            bcd_valid_q     <= bcd_valid_d;
            disp_sec_ones_q <= disp_sec_ones_d;
            disp_sec_tens_q <= disp_sec_tens_d;
            disp_min_ones_q <= disp_min_ones_d;
            disp_min_tens_q <= disp_min_tens_d;
            disp_sec_bad_q  <= disp_sec_bad_d;
            disp_min_bad_q  <= disp_min_bad_d;
            disp_valid_q    <= disp_valid_d;
            seg_q           <= seg_d;
            dp_q            <= dp_d;
            dig_q           <= dig_d;
        end
    end

    assign seg_out = seg_q;
    assign dp_out  = dp_q;
    assign dig_en  = dig_q;

endmodule

// File: tb/tb_clk_display_mux.sv
// Directed frame-by-frame bench for clk_display_mux (REFRESH_DIV=16,
// active-high segments and digits).
module tb_clk_display_mux;

    typedef struct packed {
        logic [5:0] sec;
        logic [5:0] min;
        logic [6:0] s0;
        logic [6:0] s1;
        logic [6:0] s2;
        logic [6:0] s3;
        logic       dp_plain;
        logic       dp_blink;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [5:0] sec_in;
    logic [5:0] min_in;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [3:0] dig_en;

    int total;
    int bad;
    int kcyc;

    vec_t vecs [0:9];
    vec_t v_blank;
    vec_t v37_05;
    vec_t v24_36;
    vec_t v08_47;
    vec_t prev;

    clk_display_mux #(
        .REFRESH_DIV   (16),
        .SEG_ACTIVE_LOW(1'b0),
        .DIG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seconds_in(sec_in),
        .minutes_in(min_in),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .dig_en    (dig_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [5:0] s, input logic [5:0] m,
        input logic [6:0] a, input logic [6:0] b,
        input logic [6:0] c, input logic [6:0] d,
        input logic pp, input logic pb);
        vec_t v;
        v.sec = s; v.min = m;
        v.s0 = a; v.s1 = b; v.s2 = c; v.s3 = d;
        v.dp_plain = pp; v.dp_blink = pb;
        return v;
    endfunction

    function automatic logic [6:0] slot_seg(input vec_t v, input int s);
        case (s)
            0: return v.s0;
            1: return v.s1;
            2: return v.s2;
            default: return v.s3;
        endcase
    endfunction

    function automatic logic vdp(input vec_t v);
`ifdef COLON_BLINK_EN
        return v.dp_blink;
`else
        return v.dp_plain;
`endif
    endfunction

    task automatic chk(input string name, input logic [6:0] act,
                       input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%h want=%h", name, kcyc, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        kcyc++;
    endtask

    // Steps nj cycles from a frame boundary, checking the registered pins.
    task automatic run_frame(input vec_t shown, input vec_t nxt,
                             input bit chg, input bit junk, input int nj);
        int cnt;
        int slot;
        logic [3:0] exp_dig;
        logic exp_dp;
        for (int j = 1; j <= nj; j++) begin
            tick();
            cnt  = (j - 1) % 16;
            slot = (j - 1) / 16;
            exp_dig = (cnt == 0) ? 4'h0 : (4'b0001 << slot);
            exp_dp  = (cnt != 0 && slot == 2) ? vdp(shown) : 1'b0;
            chk("dig_en", {3'b0, dig_en}, {3'b0, exp_dig});
            chk("dp_out", {6'b0, dp_out}, {6'b0, exp_dp});
            if (cnt != 0) begin
                chk("seg_out", seg_out, slot_seg(shown, slot));
            end
            if (chg && j == 24) begin
                sec_in = nxt.sec;
                min_in = nxt.min;
            end
            if (junk && j == 50) begin
                sec_in = 6'd45;
                min_in = 6'd17;
            end
        end
    endtask

    task automatic chk_reset_pins;
        chk("rst_dig", {3'b0, dig_en}, 7'h00);
        chk("rst_seg", seg_out, 7'h00);
        chk("rst_dp", {6'b0, dp_out}, 7'h00);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        kcyc  = 0;
        v_blank = mk(6'd0, 6'd0, 7'h00, 7'h00, 7'h00, 7'h00, 1'b0, 1'b0);
        v37_05  = mk(6'd37, 6'd5, 7'h07, 7'h4F, 7'h6D, 7'h3F, 1'b1, 1'b0);
        v24_36  = mk(6'd24, 6'd36, 7'h66, 7'h5B, 7'h7D, 7'h4F, 1'b1, 1'b1);
        v08_47  = mk(6'd8, 6'd47, 7'h7F, 7'h3F, 7'h07, 7'h66, 1'b1, 1'b1);
        vecs[0] = mk(6'd38, 6'd5, 7'h7F, 7'h4F, 7'h6D, 7'h3F, 1'b1, 1'b1);
        vecs[1] = mk(6'd59, 6'd59, 7'h6F, 7'h6D, 7'h6F, 7'h6D, 1'b1, 1'b0);
        vecs[2] = mk(6'd63, 6'd59, 7'h40, 7'h40, 7'h6F, 7'h6D, 1'b1, 1'b0);
        vecs[3] = mk(6'd0, 6'd0, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1, 1'b1);
        vecs[4] = mk(6'd10, 6'd0, 7'h3F, 7'h06, 7'h3F, 7'h3F, 1'b1, 1'b1);
        vecs[5] = mk(6'd11, 6'd12, 7'h06, 7'h06, 7'h5B, 7'h06, 1'b1, 1'b0);
        vecs[6] = mk(6'd42, 6'd60, 7'h5B, 7'h66, 7'h40, 7'h40, 1'b1, 1'b1);
        vecs[7] = mk(6'd63, 6'd63, 7'h40, 7'h40, 7'h40, 7'h40, 1'b1, 1'b0);
        vecs[8] = mk(6'd60, 6'd0, 7'h40, 7'h40, 7'h3F, 7'h3F, 1'b1, 1'b0);
        vecs[9] = mk(6'd1, 6'd58, 7'h06, 7'h3F, 7'h7F, 7'h6D, 1'b1, 1'b0);

        reset  = 1'b1;
        sec_in = v37_05.sec;
        min_in = v37_05.min;
        repeat (3) begin
            tick();
            chk_reset_pins();
        end
        reset = 1'b0;

        run_frame(v_blank, v_blank, 1'b0, 1'b0, 64);
        run_frame(v37_05, v37_05, 1'b0, 1'b0, 64);
        prev = v37_05;

        for (int i = 0; i < 10; i++) begin
            run_frame(prev, vecs[i], 1'b1, 1'b0, 64);
            run_frame(vecs[i], vecs[i], 1'b0, 1'b1, 64);
            prev = vecs[i];
        end

        run_frame(prev, v24_36, 1'b1, 1'b0, 64);
        run_frame(v24_36, v24_36, 1'b0, 1'b0, 50);
        reset  = 1'b1;
        sec_in = v08_47.sec;
        min_in = v08_47.min;
        tick();
        chk_reset_pins();
        reset = 1'b0;
        run_frame(v_blank, v_blank, 1'b0, 1'b0, 64);
        run_frame(v08_47, v08_47, 1'b0, 1'b0, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
